// File: rtl/ovl_pkg.sv
// Shared definitions for the multi-channel OVL checkers.
// Sampling-edge selection codes used at runtime by each checker channel.
package ovl_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_ANY  = 2'd3
    } edge_mode_t;

endpackage

// File: rtl/ovl_edge_chan.sv
// One checker channel: remembers the last observed sampling value and reports
// whether the selected sampling edge occurred this cycle.
module ovl_edge_chan
    import ovl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       armed,
    input  logic [1:0] edge_mode,
    input  logic       sampling_event,
    output logic       hit
);

    logic       prev;
    edge_mode_t mode;

    assign mode = edge_mode_t'(edge_mode);

    // While disabled the previous value is frozen, so toggles go unobserved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prev <= 1'b0;
        else if (enable)
            prev <= sampling_event;
    end

    always_comb begin
        hit = 1'b0;
        if (armed) begin
            case (mode)
                EDGE_NONE: hit = 1'b1;
                EDGE_RISE: hit = sampling_event & ~prev;
                EDGE_FALL: hit = ~sampling_event & prev;
                EDGE_ANY:  hit = sampling_event ^ prev;
                default:   hit = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ovl_always_on_edge_multi.sv
// NUM_CH-channel "always on edge" checker with sticky status, saturating fire
// counter and first-failure channel capture, clearable by software.
module ovl_always_on_edge_multi
    import ovl_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [1:0]          edge_mode,
    input  logic [NUM_CH-1:0]   sampling_event,
    input  logic [NUM_CH-1:0]   test_expr,
    input  logic                prevConfigInvalid,
    input  logic                clr_status,
    output logic                out,
    output logic [NUM_CH-1:0]   fire_vec,
    output logic [NUM_CH-1:0]   sticky,
    output logic [CNT_W-1:0]    fire_cnt,
    output logic                first_valid,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] first_ch
);

    localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              r_reset_n;
    logic [NUM_CH-1:0] hit;
    logic [ID_W-1:0]   low_ch;
    logic              low_found;

    // Armed on the first enabled cycle; prev values become valid from then on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_reset_n <= 1'b0;
        else if (enable)
            r_reset_n <= 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        ovl_edge_chan u_chan (
            .clk            (clk),
            .rst            (rst),
            .enable         (enable),
            .armed          (r_reset_n),
            .edge_mode      (edge_mode),
            .sampling_event (sampling_event[i]),
            .hit            (hit[i])
        );
    end

    assign fire_vec = {NUM_CH{~rst & enable & ~prevConfigInvalid & r_reset_n}}
                      & hit & ~test_expr;
    assign out      = |fire_vec;

    always_comb begin
        low_ch    = '0;
        low_found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (fire_vec[i] && !low_found) begin
                low_ch    = ID_W'(i);
                low_found = 1'b1;
            end
        end
    end

    // A clear still records the current cycle's fires so none are lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky      <= '0;
            fire_cnt    <= '0;
            first_valid <= 1'b0;
            first_ch    <= '0;
        end else if (clr_status) begin
            sticky      <= fire_vec;
            fire_cnt    <= CNT_W'(out);
            first_valid <= out;
            first_ch    <= out ? low_ch : '0;
        end else begin
            sticky <= sticky | fire_vec;
            if (out && (fire_cnt != '1))
                fire_cnt <= fire_cnt + CNT_W'(1);
            if (out && !first_valid) begin
                first_valid <= 1'b1;
                first_ch    <= low_ch;
            end
        end
    end

endmodule

// File: tb/tb_ovl_always_on_edge_multi.sv
// Directed and randomized checks of ovl_always_on_edge_multi against a
// behavioural model of the edge rules and status bookkeeping.
module tb_ovl_always_on_edge_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [1:0]       edge_mode;
    logic [NUM_CH-1:0] se;
    logic [NUM_CH-1:0] te;
    logic             pci;
    logic             clr;
    logic             out;
    logic [NUM_CH-1:0] fire_vec;
    logic [NUM_CH-1:0] sticky;
    logic [CNT_W-1:0] fire_cnt;
    logic             first_valid;
    logic [1:0]       first_ch;

    int tests = 0;
    int fails = 0;

    // model state
    bit        m_armed;
    bit        m_prev [NUM_CH];
    bit [3:0]  m_sticky;
    int        m_cnt;
    bit        m_fv;
    int        m_first;

    ovl_always_on_edge_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .edge_mode         (edge_mode),
        .sampling_event    (se),
        .test_expr         (te),
        .prevConfigInvalid (pci),
        .clr_status        (clr),
        .out               (out),
        .fire_vec          (fire_vec),
        .sticky            (sticky),
        .fire_cnt          (fire_cnt),
        .first_valid       (first_valid),
        .first_ch          (first_ch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [3:0] model_fire();
        bit [3:0] f = '0;
        bit h;
        if (rst || !enable || pci || !m_armed) return '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (edge_mode)
                2'd0:    h = 1'b1;
                2'd1:    h = se[i] && !m_prev[i];
                2'd2:    h = !se[i] && m_prev[i];
                default: h = se[i] != m_prev[i];
            endcase
            f[i] = h && !te[i];
        end
        return f;
    endfunction

    function automatic int lowest(input bit [3:0] f);
        for (int i = 0; i < NUM_CH; i++)
            if (f[i]) return i;
        return 0;
    endfunction

    task automatic model_clear();
        m_armed = 0;
        for (int i = 0; i < NUM_CH; i++) m_prev[i] = 0;
        m_sticky = '0;
        m_cnt = 0;
        m_fv = 0;
        m_first = 0;
    endtask

    task automatic model_update();
        bit [3:0] f;
        bit o;
        f = model_fire();
        o = |f;
        if (clr) begin
            m_sticky = f;
            m_cnt = o ? 1 : 0;
            m_fv = o;
            m_first = o ? lowest(f) : 0;
        end else begin
            m_sticky = m_sticky | f;
            if (o) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            if (o && !m_fv) begin
                m_fv = 1;
                m_first = lowest(f);
            end
        end
        if (enable) begin
            m_armed = 1;
            for (int i = 0; i < NUM_CH; i++) m_prev[i] = se[i];
        end
    endtask

    task automatic check_all(input string tag);
        bit [3:0] f;
        f = model_fire();
        chk({tag, ".fire_vec"}, fire_vec, f);
        chk({tag, ".out"}, out, |f);
        chk({tag, ".sticky"}, sticky, m_sticky);
        chk({tag, ".fire_cnt"}, fire_cnt, m_cnt);
        chk({tag, ".first_valid"}, first_valid, m_fv);
        chk({tag, ".first_ch"}, first_ch, m_first);
    endtask

    // inputs are set just after a posedge; check at negedge, then advance model at posedge
    task automatic step(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        if (!rst) model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_clear();
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; edge_mode = 2'd0; se = '0; te = '1; pci = 1'b0; clr = 1'b0;
        #2;
        do_reset();

        // T1: single rise failure on ch0
        enable = 1'b1; edge_mode = 2'd1; se = 4'b0000; te = 4'b0000;
        step("t1_arm");
        se = 4'b0001;
        #1 chk("t1_fire_vec", fire_vec, 4'b0001);
        chk("t1_out", out, 1'b1);
        step("t1_fire");
        te = 4'b1111;
        chk("t1_sticky", sticky, 4'b0001);
        chk("t1_cnt", fire_cnt, 2'd1);
        chk("t1_fv", first_valid, 1'b1);
        chk("t1_first", first_ch, 2'd0);
        step("t1_post");

        // T2: first enabled cycle after reset never fires
        enable = 1'b0;
        do_reset();
        enable = 1'b1; edge_mode = 2'd0; se = 4'b1111; te = 4'b0000;
        #1 chk("t2_first_cycle_out", out, 1'b0);
        step("t2_arm");
        chk("t2_second_out", out, 1'b1);
        chk("t2_second_vec", fire_vec, 4'b1111);
        step("t2_fire");
        chk("t2_first_ch", first_ch, 2'd0);

        // T3: fall and any edges on ch2
        edge_mode = 2'd2; se = 4'b0100; te = 4'b0000;
        step("t3_setup");
        se = 4'b0000;
        #1 chk("t3_fall_vec", fire_vec, 4'b0100);
        step("t3_fall");
        se = 4'b0100;
        #1 chk("t3_rise_in_fall", fire_vec, 4'b0000);
        step("t3_rise");
        edge_mode = 2'd3; se = 4'b0000;
        #1 chk("t3_any_fall", fire_vec, 4'b0100);
        step("t3_any1");
        se = 4'b0100;
        #1 chk("t3_any_rise", fire_vec, 4'b0100);
        step("t3_any2");

        // T4: simultaneous failures and first-channel retention
        enable = 1'b0;
        do_reset();
        enable = 1'b1; edge_mode = 2'd1; se = 4'b0000; te = 4'b1111;
        step("t4_arm");
        se = 4'b1010; te = 4'b0101;
        #1 chk("t4_vec", fire_vec, 4'b1010);
        step("t4_multi");
        chk("t4_cnt", fire_cnt, 2'd1);
        chk("t4_first", first_ch, 2'd1);
        se = 4'b1011; te = 4'b1110;
        step("t4_ch0");
        chk("t4_first_kept", first_ch, 2'd1);
        chk("t4_sticky", sticky, 4'b1011);
        chk("t4_cnt2", fire_cnt, 2'd2);

        // T5: config-invalid suppression and frozen prev while disabled
        pci = 1'b1; se = 4'b0000; te = 4'b1111;
        step("t5_pci_lo");
        se = 4'b1111; te = 4'b0000;
        #1 chk("t5_pci_out", out, 1'b0);
        step("t5_pci_rise");
        chk("t5_pci_cnt", fire_cnt, 2'd2);
        chk("t5_pci_sticky", sticky, 4'b1011);
        pci = 1'b0; se = 4'b0000; te = 4'b1111;
        step("t5_lo");
        enable = 1'b0; te = 4'b0000;
        step("t5_dis0");
        se = 4'b1111;
        step("t5_dis1");
        se = 4'b0000;
        step("t5_dis2");
        enable = 1'b1;
        #1 chk("t5_reen_out", out, 1'b0);
        step("t5_reen");

        // T6: saturation, clear with concurrent fire, async reset mid-burst
        clr = 1'b1; te = 4'b1111;
        step("t6_clr");
        clr = 1'b0; edge_mode = 2'd0; te = 4'b1110;
        for (int k = 0; k < 5; k++) step("t6_burst");
        chk("t6_sat", fire_cnt, 2'd3);
        clr = 1'b1; te = 4'b1011;
        step("t6_clr_fire");
        chk("t6_clr_cnt", fire_cnt, 2'd1);
        chk("t6_clr_sticky", sticky, 4'b0100);
        chk("t6_clr_first", first_ch, 2'd2);
        chk("t6_clr_fv", first_valid, 1'b1);
        clr = 1'b0; te = 4'b0000;
        step("t6_b1");
        step("t6_b2");
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_sticky", sticky, 4'b0000);
        chk("t6_rst_cnt", fire_cnt, 2'd0);
        chk("t6_rst_fv", first_valid, 1'b0);
        chk("t6_rst_out", out, 1'b0);
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("t6_rearm_out", out, 1'b0);
        step("t6_rearm");
        step("t6_after");

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(63) == 0) begin
                do_reset();
            end else begin
                enable    = ($urandom_range(7) != 0);
                edge_mode = 2'($urandom_range(3));
                se        = 4'($urandom);
                te        = 4'($urandom);
                pci       = ($urandom_range(7) == 0);
                clr       = ($urandom_range(15) == 0);
                step("rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
